// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the frame/baud
// constants common to the TX and RX paths.
package uart_pkg;

  localparam int unsigned UART_BAUD_DIV  = 1250;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

endpackage

// File: rtl/baudgen_rx.sv
// Receive-side baud down-counter: loadable, ticks while the count is zero.
// A load of L produces the tick L+1 cycles after the load cycle.
module baudgen_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = UART_BAUD_DIV,
  parameter int unsigned CNT_W    = $clog2(BAUD_DIV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign tick_c = (cnt == '0);

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronises rx, validates the start bit, samples data
// mid-bit LSB first, checks the stop bit and pulses valid or frame error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = UART_BAUD_DIV,
  parameter int unsigned DATA_BITS = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned HALF  = BAUD_DIV / 2;
  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);

  logic                 rx_m;
  logic                 rx_s;
  rx_state_t            state;
  rx_state_t            state_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_cnt_next;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic [DATA_BITS-1:0] data_next;
  logic                 valid_next;
  logic                 err_next;
  logic                 load;
  logic [CNT_W-1:0]     load_val;
  logic                 tick_c;

  // Two-flop synchroniser; idles high so reset never looks like a start edge
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  baudgen_rx #(
    .BAUD_DIV (BAUD_DIV),
    .CNT_W    (CNT_W)
  ) u_baudgen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .tick_c   (tick_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RX_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      shift        <= shift_next;
      rx_data      <= data_next;
      rx_valid     <= valid_next;
      rx_frame_err <= err_next;
      rx_busy      <= (state_next != RX_IDLE);
    end
  end

  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_next   = shift;
    data_next    = rx_data;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    load         = 1'b0;
    load_val     = CNT_W'(BAUD_DIV - 1);

    unique case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_next = RX_START;
          load       = 1'b1;
          load_val   = CNT_W'(HALF - 1);
        end
      end
      RX_START: begin
        // Mid start bit: a high line here was only a glitch
        if (tick_c) begin
          if (rx_s) begin
            state_next = RX_IDLE;
          end else begin
            state_next   = RX_DATA;
            load         = 1'b1;
            bit_cnt_next = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick_c) begin
          shift_next = {rx_s, shift[DATA_BITS-1:1]};
          load       = 1'b1;
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
            state_next = RX_STOP;
          end else begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      RX_STOP: begin
        if (tick_c) begin
          if (rx_s) begin
            data_next  = shift;
            valid_next = 1'b1;
            state_next = RX_IDLE;
          end else begin
            err_next   = 1'b1;
            state_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // Held-low line must return high before another frame is accepted
        if (rx_s) begin
          state_next = RX_IDLE;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized bytes and
// baud skew, checked against a byte-queue model of the serial link.
module tb_uart_rx;

  localparam int unsigned BD    = 16;
  localparam int unsigned BD2   = 1250;
  localparam int unsigned HALF  = BD / 2;
  localparam int unsigned VALID_LAT = 2 + HALF + 9 * BD + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] rx_data1, rx_data2;
  logic       rx_valid1, rx_valid2;
  logic       rx_frame_err1, rx_frame_err2;
  logic       rx_busy1, rx_busy2;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8)) dut1 (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx1),
    .rx_data      (rx_data1),
    .rx_valid     (rx_valid1),
    .rx_frame_err (rx_frame_err1),
    .rx_busy      (rx_busy1)
  );

  uart_rx #(.BAUD_DIV(BD2), .DATA_BITS(8)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx2),
    .rx_data      (rx_data2),
    .rx_valid     (rx_valid2),
    .rx_frame_err (rx_frame_err2),
    .rx_busy      (rx_busy2)
  );

  // Event recorder: received bytes, error pulses, pulse-shape violations
  logic [7:0] got1[$];
  logic [7:0] got2[$];
  int   err1 = 0, err2 = 0, both_cnt = 0, wide_cnt = 0, valid_cyc = 0;
  logic busy_at_valid = 1'b1;
  logic pv1 = 1'b0, pe1 = 1'b0, pv2 = 1'b0, pe2 = 1'b0;

  always @(negedge clk) begin
    if (rx_valid1) begin
      got1.push_back(rx_data1);
      valid_cyc     <= cyc;
      busy_at_valid <= rx_busy1;
    end
    if (rx_valid2) got2.push_back(rx_data2);
    if (rx_frame_err1) err1 <= err1 + 1;
    if (rx_frame_err2) err2 <= err2 + 1;
    if ((rx_valid1 && rx_frame_err1) || (rx_valid2 && rx_frame_err2))
      both_cnt <= both_cnt + 1;
    if ((rx_valid1 && pv1) || (rx_frame_err1 && pe1) ||
        (rx_valid2 && pv2) || (rx_frame_err2 && pe2))
      wide_cnt <= wide_cnt + 1;
    pv1 <= rx_valid1;
    pe1 <= rx_frame_err1;
    pv2 <= rx_valid2;
    pe2 <= rx_frame_err2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    #1;
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pop1();
    if (got1.size() == 0) return 8'hxx;
    return got1.pop_front();
  endfunction

  function automatic logic [7:0] pop2();
    if (got2.size() == 0) return 8'hxx;
    return got2.pop_front();
  endfunction

  // One frame at p2/2 clk cycles per bit; abort_j pulses rst during that bit
  task automatic send(input bit sel, input logic [7:0] b, input int p2,
                      input logic stop, input int abort_j, output int t0);
    logic [9:0] fr;
    int len;
    fr = {stop, b, 1'b0};
    t0 = 0;
    for (int j = 0; j < 10; j++) begin
      len = ((j + 1) * p2) / 2 - (j * p2) / 2;
      @(negedge clk);
      if (j == 0) t0 = cyc;
      if (sel) rx2 = fr[j];
      else     rx1 = fr[j];
      if (j == abort_j) begin
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx1 = 1'b1;
        rx2 = 1'b1;
        return;
      end
      repeat (len - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int p2, gap;

    repeat (3) @(negedge clk);
    check("reset_data", rx_data1, 8'h00);
    check("reset_flags", {rx_valid1, rx_frame_err1, rx_busy1}, 3'b000);
    rst = 1'b0;
    idle(5);

    send(0, 8'hA5, 2 * BD, 1'b1, -1, t);
    idle(4);
    check("a5_count", got1.size(), 1);
    check("a5_data", pop1(), 8'hA5);
    check("a5_latency", valid_cyc - t, VALID_LAT);
    check("a5_busy_at_valid", busy_at_valid, 1'b0);
    check("a5_no_err", err1, 0);

    // Glitch shorter than half a bit
    @(negedge clk);
    rx1 = 1'b0;
    repeat (3) @(negedge clk);
    check("glitch_busy", rx_busy1, 1'b1);
    @(negedge clk);
    idle(20);
    check("glitch_idle", rx_busy1, 1'b0);
    check("glitch_no_valid", got1.size(), 0);
    check("glitch_no_err", err1, 0);

    // Bad stop bit, then line held low
    send(0, 8'h3C, 2 * BD, 1'b0, -1, t);
    repeat (40) @(negedge clk);
    check("ferr_count", err1, 1);
    check("ferr_no_valid", got1.size(), 0);
    check("ferr_data_held", rx_data1, 8'hA5);
    check("ferr_break_busy", rx_busy1, 1'b1);
    idle(20);
    check("ferr_recover_idle", rx_busy1, 1'b0);
    check("ferr_single_pulse", err1, 1);
    send(0, 8'h81, 2 * BD, 1'b1, -1, t);
    idle(4);
    check("after_ferr_data", pop1(), 8'h81);

    // Back-to-back with no idle bits
    send(0, 8'h00, 2 * BD, 1'b1, -1, t);
    send(0, 8'hFF, 2 * BD, 1'b1, -1, t);
    send(0, 8'h55, 2 * BD, 1'b1, -1, t);
    idle(4);
    check("b2b_count", got1.size(), 3);
    check("b2b_0", pop1(), 8'h00);
    check("b2b_1", pop1(), 8'hFF);
    check("b2b_2", pop1(), 8'h55);

    // Reset during data bit 3
    send(0, 8'hC3, 2 * BD, 1'b1, 4, t);
    idle(4);
    check("rst_data", rx_data1, 8'h00);
    check("rst_busy", rx_busy1, 1'b0);
    idle(10 * BD);
    check("rst_no_valid", got1.size(), 0);
    check("rst_no_err", err1, 1);
    check("rst_data_held", rx_data1, 8'h00);
    send(0, 8'h12, 2 * BD, 1'b1, -1, t);
    idle(4);
    check("rst_then_data", pop1(), 8'h12);
    check("rst_then_rx_data", rx_data1, 8'h12);

    // About +/-3% skew using half-cycle bit periods
    send(0, 8'h5A, 2 * BD + 1, 1'b1, -1, t);
    idle(4);
    check("skew_slow", pop1(), 8'h5A);
    send(0, 8'h5A, 2 * BD - 1, 1'b1, -1, t);
    idle(4);
    check("skew_fast", pop1(), 8'h5A);

    // Random bytes, skew and gaps against the byte-queue model
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom_range(0, 255));
      p2  = 2 * BD - 1 + int'($urandom_range(0, 2));
      gap = int'($urandom_range(0, 2)) * BD;
      send(0, b, p2, 1'b1, -1, t);
      exp_q.push_back(b);
      if (gap != 0) idle(gap);
    end
    idle(4);
    check("rand_count", got1.size(), exp_q.size());
    while (exp_q.size() != 0) check("rand_data", pop1(), exp_q.pop_front());

    // Full-rate divider with 1288 and 1212 cycles per bit
    send(1, 8'h5A, 2 * 1288, 1'b1, -1, t);
    idle(4);
    check("bd1250_slow", pop2(), 8'h5A);
    send(1, 8'h5A, 2 * 1212, 1'b1, -1, t);
    idle(4);
    check("bd1250_fast", pop2(), 8'h5A);
    check("bd1250_no_err", err2, 0);

    check("pulse_exclusive", both_cnt, 0);
    check("pulse_width", wide_cnt, 0);
    check("total_err", err1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
